// File: rtl/systolic_feed_ctrl.sv
// rtl/systolic_feed_ctrl.sv - skewed read sequencer feeding the systolic PE array row FIFOs
module systolic_feed_ctrl #(
   parameter int ROWS  = 4,
   parameter int CNTW  = 5,
   parameter int DRAIN = 4
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic            start,
   input  logic [CNTW-1:0] k_len,
   input  logic [ROWS-1:0] buf_empty,
   output logic [ROWS-1:0] buf_read,
   output logic [ROWS-1:0] pe_valid,
   output logic            busy,
   output logic            stall,
   output logic            done
);

   localparam int TW = CNTW + 4;
   localparam int DW = $clog2(DRAIN + 1);

   typedef enum logic [1:0] {IDLE, FEED, DRAIN_S, DONE} state_t;

   state_t          state;
   logic [TW-1:0]   t;
   logic [CNTW-1:0] kl;
   logic [DW-1:0]   dc;
   logic [ROWS-1:0] want;
   logic [TW-1:0]   last_t;
   logic            blocked;

   assign last_t = TW'(kl) + TW'(ROWS) - TW'(2);

   // Row r is inside its window on wavefront cycles r .. r+kl-1.
   always_comb begin
      want = '0;
      if (state == FEED) begin
         for (int r = 0; r < ROWS; r++) begin
            want[r] = (t >= TW'(r)) && (t < TW'(r) + TW'(kl));
         end
      end
   end

   // Any blocked row freezes every row so the diagonal skew survives underflow.
   assign blocked  = |(want & buf_empty);
   assign stall    = blocked;
   assign buf_read = blocked ? '0 : want;
   assign pe_valid = buf_read;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state <= IDLE;
         t     <= '0;
         kl    <= '0;
         dc    <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  if (k_len != '0) begin
                     kl    <= k_len;
                     t     <= '0;
                     busy  <= 1'b1;
                     state <= FEED;
                  end else begin
                     done  <= 1'b1;
                     state <= DONE;
                  end
               end
            end
            FEED: begin
               if (!blocked) begin
                  t <= t + TW'(1);
                  if (t == last_t) begin
                     dc    <= '0;
                     state <= DRAIN_S;
                  end
               end
            end
            DRAIN_S: begin
               if (dc == DW'(DRAIN - 1)) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end else begin
                  dc <= dc + DW'(1);
               end
            end
            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// tb/tb_systolic_feed_ctrl.sv - scoreboard bench for systolic_feed_ctrl
module tb_systolic_feed_ctrl;

   localparam int ROWS  = 4;
   localparam int CNTW  = 5;
   localparam int DRAIN = 4;

   logic            clk = 1'b0;
   logic            rstn;
   logic            start;
   logic [CNTW-1:0] k_len;
   logic [ROWS-1:0] buf_empty;
   logic [ROWS-1:0] buf_read;
   logic [ROWS-1:0] pe_valid;
   logic            busy;
   logic            stall;
   logic            done;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [ROWS-1:0] rd;
      logic            st;
      logic            bz;
      logic            dn;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   systolic_feed_ctrl #(.ROWS(ROWS), .CNTW(CNTW), .DRAIN(DRAIN)) dut (
      .clk(clk), .rstn(rstn), .start(start), .k_len(k_len),
      .buf_empty(buf_empty), .buf_read(buf_read), .pe_valid(pe_valid),
      .busy(busy), .stall(stall), .done(done)
   );

   task automatic test_reset();
      rstn = 1'b0; start = 1'b0; k_len = '0; buf_empty = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({buf_read, pe_valid, busy, stall, done} !== '0) begin
         failures++;
         $display("FAIL reset_outputs got rd=%b pv=%b busy=%b stall=%b done=%b want all 0",
                  buf_read, pe_valid, busy, stall, done);
      end
      @(posedge clk); #1 rstn = 1'b1;
   endtask

   // Builds the expected per-cycle trace, then drives the tile and checks it cycle by cycle.
   task automatic run_tile(input string name, input int kl, input int stall_t,
                           input int stall_row, input bit restart);
      int   cnt[ROWS];
      int   idx;
      int   feed_cycles;
      exp_t e;
      logic [ROWS-1:0] w;
      for (int r = 0; r < ROWS; r++) cnt[r] = 0;
      sb.delete();
      if (kl == 0) begin
         e = '{rd: '0, st: 1'b0, bz: 1'b0, dn: 1'b1}; sb.push_back(e);
      end else begin
         for (int tt = 0; tt <= kl + ROWS - 2; tt++) begin
            w = '0;
            for (int r = 0; r < ROWS; r++) w[r] = (tt >= r) && (tt < r + kl);
            if (tt == stall_t) begin
               e = '{rd: '0, st: 1'b1, bz: 1'b1, dn: 1'b0}; sb.push_back(e);
            end
            e = '{rd: w, st: 1'b0, bz: 1'b1, dn: 1'b0}; sb.push_back(e);
         end
         for (int d = 0; d < DRAIN; d++) begin
            e = '{rd: '0, st: 1'b0, bz: 1'b1, dn: 1'b0}; sb.push_back(e);
         end
         e = '{rd: '0, st: 1'b0, bz: 1'b0, dn: 1'b1}; sb.push_back(e);
      end
      e = '{rd: '0, st: 1'b0, bz: 1'b0, dn: 1'b0}; sb.push_back(e);

      @(posedge clk); #1 start = 1'b1; k_len = CNTW'(kl); buf_empty = '0;
      idx = 0;
      feed_cycles = 0;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         @(posedge clk); #1;
         start = (restart && idx == 2);
         if (restart && idx == 2) k_len = CNTW'(7);
         buf_empty = e.st ? ROWS'(1 << stall_row) : '0;
         @(negedge clk);
         if (busy && !done && e.bz) feed_cycles += (buf_read != '0 || stall) ? 1 : 0;
         for (int r = 0; r < ROWS; r++) cnt[r] += buf_read[r] ? 1 : 0;
         checks++;
         if (buf_read !== e.rd || pe_valid !== e.rd) begin
            failures++;
            $display("FAIL %s read[%0d] got rd=%b pv=%b want %b", name, idx, buf_read, pe_valid, e.rd);
         end
         checks++;
         if (stall !== e.st || busy !== e.bz || done !== e.dn) begin
            failures++;
            $display("FAIL %s ctrl[%0d] got stall=%b busy=%b done=%b want %b %b %b",
                     name, idx, stall, busy, done, e.st, e.bz, e.dn);
         end
         idx++;
      end
      for (int r = 0; r < ROWS; r++) begin
         checks++;
         if (cnt[r] != kl) begin
            failures++;
            $display("FAIL %s row%0d_reads got %0d want %0d", name, r, cnt[r], kl);
         end
      end
      checks++;
      if (kl > 0 && feed_cycles != kl + ROWS - 1 + ((stall_t >= 0) ? 1 : 0)) begin
         failures++;
         $display("FAIL %s feed_len got %0d want %0d", name, feed_cycles,
                  kl + ROWS - 1 + ((stall_t >= 0) ? 1 : 0));
      end
      start = 1'b0;
   endtask

   task automatic test_basic();       run_tile("basic_k3", 3, -1, 0, 1'b0);  endtask
   task automatic test_stall();       run_tile("stall_k3", 3, 3, 2, 1'b0);   endtask
   task automatic test_zero_len();    run_tile("zero_k", 0, -1, 0, 1'b0);    endtask
   task automatic test_back_to_back();
      run_tile("restart_ignored", 3, -1, 0, 1'b1);
      run_tile("k7", 7, -1, 0, 1'b0);
   endtask
   task automatic test_max_len();     run_tile("k31", 31, -1, 0, 1'b0);      endtask

   task automatic test_mid_reset();
      bit saw_done = 1'b0;
      @(posedge clk); #1 start = 1'b1; k_len = CNTW'(3); buf_empty = '0;
      @(posedge clk); #1 start = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (buf_read !== 4'b0111) begin
         failures++;
         $display("FAIL mid_reset_t2 got rd=%b want 0111", buf_read);
      end
      @(posedge clk); #1 rstn = 1'b0;
      @(posedge clk); #1 rstn = 1'b1;
      @(negedge clk);
      checks++;
      if ({buf_read, pe_valid, busy, stall, done} !== '0) begin
         failures++;
         $display("FAIL mid_reset_outputs got rd=%b busy=%b stall=%b done=%b want all 0",
                  buf_read, busy, stall, done);
      end
      repeat (12) begin
         @(negedge clk);
         if (done || busy || buf_read != '0) saw_done = 1'b1;
      end
      checks++;
      if (saw_done) begin
         failures++;
         $display("FAIL mid_reset_quiet got activity=1 want 0");
      end
      run_tile("after_reset", 3, -1, 0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_zero_len();
      test_back_to_back();
      test_mid_reset();
      test_max_len();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got running want finished");
      $fatal(1);
   end

endmodule
